// File: rtl/tcdm_resp_pkg.sv
// Shared types and helpers for the TCDM SRAM responder.
`timescale 1ns/1ps

package tcdm_resp_pkg;

   // Read data returned with every error response so software can spot a bad access.
   localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

   // One entry of the response pipe: a pending response and what kind it is.
   typedef struct packed {
      logic valid;
      logic err;
      logic is_read;
   } resp_slot_t;

   // Window check done in 64 bits so base+size cannot wrap at the top of the address space.
   function automatic logic addr_in_range(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input logic [63:0] size);
      return (addr >= base) && (addr < (base + size));
   endfunction

endpackage

// File: rtl/tcdm_sram_responder_if.sv
// TCDM req/gnt/r_valid bus between a core master and the SRAM responder.
`timescale 1ns/1ps

interface tcdm_sram_responder_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   logic                  req;
   logic [ADDR_WIDTH-1:0] add;
   logic                  wen;
   logic [DATA_WIDTH-1:0] wdata;
   logic [BE_WIDTH-1:0]   be;
   logic                  gnt;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_opc;

   modport master (
      output req, add, wen, wdata, be,
      input  gnt, r_valid, r_rdata, r_opc
   );

   modport slave (
      input  req, add, wen, wdata, be,
      output gnt, r_valid, r_rdata, r_opc
   );

endinterface

// File: rtl/tcdm_resp_pipe.sv
// Fixed-depth shift register that delays response descriptors to match the SRAM latency.
`timescale 1ns/1ps

module tcdm_resp_pipe
   import tcdm_resp_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  resp_slot_t push_slot,
   output resp_slot_t out_slot
);

   resp_slot_t slots [DEPTH];

   // Shift every cycle; reset drops everything in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            slots[i] <= '0;
         end
      end else begin
         slots[0] <= push_slot;
         for (int i = 1; i < DEPTH; i++) begin
            slots[i] <= slots[i-1];
         end
      end
   end

   assign out_slot = slots[DEPTH-1];

endmodule

// File: rtl/tcdm_sram_responder.sv
// TCDM bus slave terminating a master port onto a fixed-latency single-port SRAM.
`timescale 1ns/1ps

module tcdm_sram_responder
   import tcdm_resp_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH     = 32,
   parameter int unsigned            DATA_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = 32'h1C000000,
   parameter int unsigned            MEM_SIZE_BYTES = 65536,
   parameter int unsigned            SRAM_LATENCY   = 1,
   localparam int unsigned           BE_WIDTH       = DATA_WIDTH / 8,
   localparam int unsigned           SRAM_AW        = $clog2(MEM_SIZE_BYTES / BE_WIDTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   tcdm_sram_responder_if.slave  bus,
   input  logic                  stall_i,
   output logic                  sram_req_o,
   output logic                  sram_we_o,
   output logic [SRAM_AW-1:0]    sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   output logic [BE_WIDTH-1:0]   sram_be_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i,
   output logic [7:0]            err_count_o
);

   localparam int unsigned OFFS_BITS = $clog2(BE_WIDTH);

   logic       granted;
   logic       in_range;
   resp_slot_t push_slot;
   resp_slot_t out_slot;
   logic [7:0] err_count;

   assign granted  = bus.req & ~stall_i;
   assign in_range = addr_in_range(64'(bus.add), 64'(BASE_ADDR), 64'(MEM_SIZE_BYTES));
   assign bus.gnt  = granted;

   // SRAM is driven in the grant cycle; out-of-range and reset keep the macro idle.
   always_comb begin
      sram_req_o   = granted & in_range & rst_ni;
      sram_we_o    = sram_req_o & ~bus.wen;
      sram_addr_o  = SRAM_AW'((bus.add - BASE_ADDR) >> OFFS_BITS);
      sram_wdata_o = bus.wdata;
      sram_be_o    = bus.be;
   end

   // Every grant gets a slot, so errors share the SRAM latency and stay in order.
   always_comb begin
      push_slot.valid   = granted;
      push_slot.err     = ~in_range;
      push_slot.is_read = bus.wen;
   end

   tcdm_resp_pipe #(
      .DEPTH (SRAM_LATENCY)
   ) u_resp_pipe (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push_slot (push_slot),
      .out_slot  (out_slot)
   );

   // Response mux: read data only for good reads, the error pattern for errors, zero otherwise.
   always_comb begin
      bus.r_valid = out_slot.valid;
      bus.r_rdata = '0;
      bus.r_opc   = 1'b0;
      if (out_slot.valid) begin
         if (out_slot.err) begin
            bus.r_rdata = DATA_WIDTH'(ERR_RDATA);
            bus.r_opc   = 1'b1;
         end else if (out_slot.is_read) begin
            bus.r_rdata = sram_rdata_i;
         end
      end
   end

   // Count error responses as they leave the pipe, sticking at all-ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_count <= 8'd0;
      end else if (out_slot.valid && out_slot.err && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end

   assign err_count_o = err_count;

endmodule
